// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_peer block: FSM state encodings,
// default bit timing and frame geometry.
package uart_pkg;

  // 9600 baud at the nominal system clock.
  localparam int CLKS_PER_BIT_DEF = 2502;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_peer_if.sv
// Byte-stream handshakes between the local consumer/producer and uart_peer.
interface uart_peer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  // Local logic that feeds bytes out and drains received bytes.
  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  // The UART itself.
  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/uart_peer_fifo.sv
// Small power-of-two receive FIFO with wrapping pointers. A push into a full
// FIFO is dropped unless a pop happens in the same cycle; rd_data reads as
// zero while empty so the consumer never sees stale storage.
module uart_peer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       not_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full      = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign do_pop    = pop & not_empty;
  assign do_push   = push & (~full | do_pop);
  assign drop      = push & full & ~do_pop;
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  // Storage is data-only: no reset needed, validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_peer.sv
// 8N1 UART peer with RTS/CTS flow control. The transmitter only starts a frame
// while the remote raises rts_in; the receiver buffers into a 4-entry FIFO and
// asks the remote to pause (cts_n_out high) once three bytes are waiting.
module uart_peer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_peer_if.slave  bus,
  output logic        tx,
  input  logic        rx,
  input  logic        rts_in,
  output logic        cts_n_out,
  output logic        frame_error,
  output logic        rx_overrun,
  input  logic        err_clear
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_fire;
  logic             tx_bit_end;

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign tx_fire      = bus.tx_valid & bus.tx_ready & rts_in;
  assign tx_bit_end   = (tx_cnt == BIT_LAST);

  // TX sequencer: once started, a frame always runs to its stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          tx_bit <= '0;
          if (tx_fire) tx_state <= TX_START;
        end
        TX_START: begin
          tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
          if (tx_bit_end) tx_state <= TX_DATA;
        end
        TX_DATA: begin
          tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
          if (tx_bit_end) begin
            if (tx_bit == LAST_BIT) tx_state <= TX_STOP;
            else                    tx_bit   <= tx_bit + 3'd1;
          end
        end
        default: begin
          tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
          if (tx_bit_end) tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // TX byte latch and LSB-first shifter.
  always_ff @(posedge clk) begin
    if (tx_fire)                                tx_shift <= bus.tx_data;
    else if (tx_state == TX_DATA && tx_bit_end) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // Registered line driver so tx is glitch-free; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx <= 1'b1;
    else begin
      case (tx_state)
        TX_START: tx <= 1'b0;
        TX_DATA:  tx <= tx_shift[0];
        default:  tx <= 1'b1;
      endcase
    end
  end

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_e        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_bit_end;
  logic             rx_push;
  logic             rx_bad;
  logic             fifo_drop;
  logic [2:0]       fifo_count;

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_push    = (rx_state == RX_STOP) & rx_bit_end &  rx_sync;
  assign rx_bad     = (rx_state == RX_STOP) & rx_bit_end & ~rx_sync;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX sequencer: verify start at mid-bit, then sample each bit one period on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_prev & ~rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + CNT_W'(1);
          if (rx_bit_end) begin
            if (rx_bit == LAST_BIT) rx_state <= RX_STOP;
            else                    rx_bit   <= rx_bit + 3'd1;
          end
        end
        default: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + CNT_W'(1);
          if (rx_bit_end) rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // RX deserializer: bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_bit_end) rx_shift <= {rx_sync, rx_shift[7:1]};
  end

  uart_peer_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .wr_data   (rx_shift),
    .pop       (bus.rx_ready),
    .rd_data   (bus.rx_data),
    .not_empty (bus.rx_valid),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  // Status flags: error pulse, sticky overrun (set beats clear), flow control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_error <= 1'b0;
      rx_overrun  <= 1'b0;
      cts_n_out   <= 1'b0;
    end else begin
      frame_error <= rx_bad;
      if (fifo_drop)      rx_overrun <= 1'b1;
      else if (err_clear) rx_overrun <= 1'b0;
      cts_n_out <= (fifo_count >= 3'd3);
    end
  end
endmodule

// File: tb/tb_uart_peer.sv
// Directed bench for uart_peer at 16 clocks per bit.
module tb_uart_peer;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  logic rx;
  logic rts_in;
  logic cts_n_out;
  logic frame_error;
  logic rx_overrun;
  logic err_clear;

  int n_checks = 0;
  int n_err    = 0;
  int fe_cnt   = 0;

  uart_peer_if bus ();

  uart_peer #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .tx          (tx),
    .rx          (rx),
    .rts_in      (rts_in),
    .cts_n_out   (cts_n_out),
    .frame_error (frame_error),
    .rx_overrun  (rx_overrun),
    .err_clear   (err_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_error) fe_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one 8N1 frame onto rx; caller is on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Expected tx level k falling edges after the handshake edge.
  function automatic logic exp_tx_at(input int k, input logic [7:0] b);
    int idx;
    if (k < 2 || k > 161) return 1'b1;
    idx = (k - 2) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  initial begin
    logic [7:0] byte_a5;
    rst_n = 1'b0; rx = 1'b1; rts_in = 1'b0; err_clear = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0); chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_cts", cts_n_out, 0); chk("rst_fe", frame_error, 0);
    chk("rst_ovr", rx_overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full TX frame of 0xA5; rts drops mid-frame without aborting it.
    byte_a5 = 8'hA5;
    bus.tx_valid = 1'b1; bus.tx_data = byte_a5; rts_in = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (k == 1) bus.tx_valid = 1'b0;
      if (k == 50) rts_in = 1'b0;
      chk("tx_a5_line", tx, exp_tx_at(k, byte_a5));
      chk("tx_a5_ready", bus.tx_ready, (k <= 160) ? 1'b0 : 1'b1);
    end

    // No handshake without rts_in; raising it starts the frame.
    bus.tx_valid = 1'b1; bus.tx_data = 8'h5A; rts_in = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k % 10 == 0) begin
        chk("rts0_tx", tx, 1); chk("rts0_ready", bus.tx_ready, 1);
      end
    end
    rts_in = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("rts_rise_1edge", tx, 1);
    @(negedge clk);
    chk("rts_rise_2edge", tx, 0);
    repeat (170) @(negedge clk);
    chk("rts_done_ready", bus.tx_ready, 1);

    // Receive 0x3C, then pop it.
    send_frame(8'h3C, 1'b1);
    chk("rx3c_valid", bus.rx_valid, 1); chk("rx3c_data", bus.rx_data, 8'h3C);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    chk("rx3c_pop_valid", bus.rx_valid, 0); chk("rx3c_pop_data", bus.rx_data, 0);

    // Short glitch is a false start.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", bus.rx_valid, 0); chk("glitch_fe", fe_cnt, 0);

    // Bad stop bit: one error pulse, nothing stored.
    send_frame(8'h96, 1'b0);
    repeat (20) @(negedge clk);
    chk("badstop_fe", fe_cnt, 1); chk("badstop_valid", bus.rx_valid, 0);

    // Fill past capacity with flow control and overrun.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 2) chk("fill2_cts", cts_n_out, 0);
      if (i == 3) chk("fill3_cts", cts_n_out, 1);
      if (i == 4) chk("fill4_ovr", rx_overrun, 0);
      if (i == 5) chk("fill5_ovr", rx_overrun, 1);
    end
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", bus.rx_valid, 1); chk("drain_data", bus.rx_data, 32'(i));
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      @(negedge clk);
    end
    chk("drain_empty", bus.rx_valid, 0); chk("drain_cts", cts_n_out, 0);
    chk("ovr_sticky", rx_overrun, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("ovr_cleared", rx_overrun, 0);

    // TX and RX concurrently.
    fork
      send_frame(8'hC3, 1'b1);
      begin
        bus.tx_valid = 1'b1; bus.tx_data = 8'h81; rts_in = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
          @(negedge clk);
          if (k == 1) bus.tx_valid = 1'b0;
          if (k == 2)  chk("dup_tx_start", tx, 0);
          if (k == 18) chk("dup_tx_b0", tx, 1);
          if (k == 34) chk("dup_tx_b1", tx, 0);
        end
      end
    join
    chk("dup_rx_valid", bus.rx_valid, 1); chk("dup_rx_data", bus.rx_data, 8'hC3);
    repeat (10) @(negedge clk);

    // Reset in the middle of a frame of zeros while a byte is queued.
    bus.tx_valid = 1'b1; bus.tx_data = 8'h00;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) bus.tx_valid = 1'b0;
    end
    chk("pre_rst_tx", tx, 0); chk("pre_rst_valid", bus.rx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1); chk("midrst_ready", bus.tx_ready, 1);
    chk("midrst_valid", bus.rx_valid, 0); chk("midrst_data", bus.rx_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_tx", tx, 1); chk("post_rst_ready", bus.tx_ready, 1);
    chk("post_rst_valid", bus.rx_valid, 0); chk("post_rst_cts", cts_n_out, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
